// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register: DEPTH cascaded stages of {valid, pc, ctrl, data}
// with hold, bubble and flush control plus saturating hazard counters and occupancy.
module pipe_stage_reg #(
    parameter int                DATA_W    = 96,
    parameter int                CTRL_W    = 16,
    parameter int                PC_W      = 32,
    parameter logic [PC_W-1:0]   PC_RESET  = 32'h8000_0000,
    parameter int                DEPTH     = 1,
    parameter logic [CTRL_W-1:0] KILL_MASK = 16'h0007,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              bubble,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  v_q, v_n;
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [PC_W-1:0]   pc_n   [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_n [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_n [DEPTH];
    logic [2:0]        occ_n;
    logic              live_in;

    assign live_in = in_valid & ~bubble;

    // Flush kills in place without shifting; hold freezes; otherwise advance.
    always_comb begin
        v_n    = v_q;
        pc_n   = pc_q;
        ctrl_n = ctrl_q;
        data_n = data_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_n[i]    = 1'b0;
                ctrl_n[i] = ctrl_q[i] & ~KILL_MASK;
            end
        end else if (!hold) begin
            for (int i = 1; i < DEPTH; i++) begin
                v_n[i]    = v_q[i-1];
                pc_n[i]   = pc_q[i-1];
                ctrl_n[i] = ctrl_q[i-1];
                data_n[i] = data_q[i-1];
            end
            v_n[0]    = live_in;
            pc_n[0]   = in_pc;
            ctrl_n[0] = live_in ? in_ctrl : (in_ctrl & ~KILL_MASK);
            data_n[0] = in_data;
        end
    end

    always_comb begin
        occ_n = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_n = occ_n + {2'b00, v_n[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q       <= '0;
            occupancy <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= PC_RESET;
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            v_q       <= v_n;
            pc_q      <= pc_n;
            ctrl_q    <= ctrl_n;
            data_q    <= data_n;
            occupancy <= occ_n;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            hold_cnt   <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (hold && !flush && hold_cnt != '1)
                hold_cnt <= hold_cnt + CNT_W'(1);
            if (bubble && !hold && !flush && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_pc    = pc_q[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: three instances (DEPTH 1/2/3, the first with 4-bit counters) share stimulus
// and are compared every cycle against a queue-based pipeline model.
module tb_pipe_stage_reg;

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit [15:0] ctrl;
        bit [95:0] data;
    } ent_t;

    typedef struct {
        ent_t out;
        int   occ;
        int   hc;
        int   bc;
        int   fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, hold = 1'b0, bubble = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [15:0] in_ctrl = '0;
    logic [95:0] in_data = '0;

    logic        ov   [3];
    logic [31:0] opc  [3];
    logic [15:0] octl [3];
    logic [95:0] odat [3];
    logic [2:0]  occ  [3];
    logic [3:0]  hc1, bc1, fc1;
    logic [15:0] hc2, bc2, fc2, hc3, bc3, fc3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1), .CNT_W(4)) u_d1 (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_pc(opc[0]), .out_ctrl(octl[0]), .out_data(odat[0]),
        .occupancy(occ[0]), .hold_cnt(hc1), .bubble_cnt(bc1), .flush_cnt(fc1));

    pipe_stage_reg #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_pc(opc[1]), .out_ctrl(octl[1]), .out_data(odat[1]),
        .occupancy(occ[1]), .hold_cnt(hc2), .bubble_cnt(bc2), .flush_cnt(fc2));

    pipe_stage_reg #(.DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[2]), .out_pc(opc[2]), .out_ctrl(octl[2]), .out_data(odat[2]),
        .occupancy(occ[2]), .hold_cnt(hc3), .bubble_cnt(bc3), .flush_cnt(fc3));

    logic [15:0] hca [3];
    logic [15:0] bca [3];
    logic [15:0] fca [3];
    assign hca[0] = {12'd0, hc1};
    assign bca[0] = {12'd0, bc1};
    assign fca[0] = {12'd0, fc1};
    assign hca[1] = hc2;
    assign bca[1] = bc2;
    assign fca[1] = fc2;
    assign hca[2] = hc3;
    assign bca[2] = bc3;
    assign fca[2] = fc3;

    // Reference model: each pipe is a queue, newest entry at the front, output at the back.
    int   depth [3] = '{1, 2, 3};
    int   cmax  [3] = '{15, 65535, 65535};
    ent_t mq    [3][$];
    int   m_hc  [3] = '{0, 0, 0};
    int   m_bc  [3] = '{0, 0, 0};
    int   m_fc  [3] = '{0, 0, 0};
    exp_t exp_q [3][$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_step();
        ent_t e;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                mq[d].delete();
                for (int k = 0; k < depth[d]; k++) mq[d].push_back('{1'b0, 32'h8000_0000, 16'h0, 96'h0});
            end else if (flush) begin
                for (int k = 0; k < mq[d].size(); k++) begin
                    e = mq[d][k];
                    e.v = 1'b0;
                    e.ctrl = e.ctrl & ~16'h0007;
                    mq[d][k] = e;
                end
            end else if (!hold) begin
                e.v    = in_valid && !bubble;
                e.pc   = in_pc;
                e.ctrl = e.v ? in_ctrl : (in_ctrl & ~16'h0007);
                e.data = in_data;
                mq[d].push_front(e);
                void'(mq[d].pop_back());
            end
            if (reset || cnt_clr) begin
                m_hc[d] = 0;
                m_bc[d] = 0;
                m_fc[d] = 0;
            end else begin
                if (hold && !flush) m_hc[d] = (m_hc[d] < cmax[d]) ? m_hc[d] + 1 : m_hc[d];
                if (bubble && !hold && !flush) m_bc[d] = (m_bc[d] < cmax[d]) ? m_bc[d] + 1 : m_bc[d];
                if (flush) m_fc[d] = (m_fc[d] < cmax[d]) ? m_fc[d] + 1 : m_fc[d];
            end
        end
    endtask

    task automatic push_exp();
        exp_t x;
        for (int d = 0; d < 3; d++) begin
            x.out = mq[d][mq[d].size() - 1];
            x.occ = 0;
            for (int k = 0; k < mq[d].size(); k++) x.occ += int'(mq[d][k].v);
            x.hc = m_hc[d];
            x.bc = m_bc[d];
            x.fc = m_fc[d];
            exp_q[d].push_back(x);
        end
    endtask

    // Apply one edge worth of inputs; the expected post-edge state is queued at the edge.
    task automatic cyc(input bit rst, input bit hld, input bit bub, input bit fl, input bit clr,
                       input bit iv, input logic [31:0] ipc, input logic [15:0] ictrl);
        reset = rst; hold = hld; bubble = bub; flush = fl; cnt_clr = clr;
        in_valid = iv; in_pc = ipc; in_ctrl = ictrl;
        in_data = {$urandom, $urandom, $urandom};
        model_step();
        @(posedge clk);
        push_exp();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() > 0) begin
                x = exp_q[d].pop_front();
                chk($sformatf("d%0d out_valid", d + 1), 96'(ov[d]), 96'(x.out.v));
                chk($sformatf("d%0d out_pc", d + 1), 96'(opc[d]), 96'(x.out.pc));
                chk($sformatf("d%0d out_ctrl", d + 1), 96'(octl[d]), 96'(x.out.ctrl));
                chk($sformatf("d%0d out_data", d + 1), odat[d], x.out.data);
                chk($sformatf("d%0d occupancy", d + 1), 96'(occ[d]), 96'(x.occ));
                chk($sformatf("d%0d hold_cnt", d + 1), 96'(hca[d]), 96'(x.hc));
                chk($sformatf("d%0d bubble_cnt", d + 1), 96'(bca[d]), 96'(x.bc));
                chk($sformatf("d%0d flush_cnt", d + 1), 96'(fca[d]), 96'(x.fc));
            end
        end
    end

    initial begin
        #1;
        // reset for two edges
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        @(negedge clk);
        chk("reset d1 out_valid", 96'(ov[0]), 96'd0);
        chk("reset d1 out_pc", 96'(opc[0]), 96'h8000_0000);
        chk("reset d1 out_ctrl", 96'(octl[0]), 96'd0);
        chk("reset d1 out_data", odat[0], 96'd0);
        chk("reset d1 occupancy", 96'(occ[0]), 96'd0);
        chk("reset d1 hold_cnt", 96'(hc1), 96'd0);

        // stream three entries
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_0004, 16'h0011);
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_0008, 16'h0022);
        @(negedge clk);
        chk("stream d2 pc edge2", 96'(opc[1]), 96'h8000_0004);
        chk("stream d2 occupancy", 96'(occ[1]), 96'd2);
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_000C, 16'h0033);
        @(negedge clk);
        chk("stream d2 pc edge3", 96'(opc[1]), 96'h8000_0008);

        // load-use bubble
        cyc(0, 0, 1, 0, 0, 1, 32'h8000_0100, 16'h00FF);
        @(negedge clk);
        chk("bubble d1 out_valid", 96'(ov[0]), 96'd0);
        chk("bubble d1 out_ctrl", 96'(octl[0]), 96'h00F8);
        chk("bubble d1 out_pc", 96'(opc[0]), 96'h8000_0100);
        chk("bubble d1 bubble_cnt", 96'(bc1), 96'd1);

        // hold three cycles with changing input and a bubble during the hold
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_0010, 16'h0044);
        cyc(0, 1, 0, 0, 0, 1, 32'h8000_0020, 16'h0055);
        cyc(0, 1, 1, 0, 0, 1, 32'h8000_0030, 16'h0066);
        cyc(0, 1, 0, 0, 0, 1, 32'h8000_0040, 16'h0077);
        @(negedge clk);
        chk("hold d1 out_pc", 96'(opc[0]), 96'h8000_0010);
        chk("hold d1 hold_cnt", 96'(hc1), 96'd3);
        chk("hold d1 bubble_cnt", 96'(bc1), 96'd1);

        // fill DEPTH=3 with live entries, then flush together with hold
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 32'h8000_0200 + 32'(4 * i), 16'hFFFF);
        @(negedge clk);
        chk("fill d3 occupancy", 96'(occ[2]), 96'd3);
        cyc(0, 1, 0, 1, 0, 1, 32'h8000_0300, 16'hFFFF);
        @(negedge clk);
        chk("flush d3 out_valid", 96'(ov[2]), 96'd0);
        chk("flush d3 out_ctrl", 96'(octl[2]), 96'hFFF8);
        chk("flush d3 occupancy", 96'(occ[2]), 96'd0);
        chk("flush d3 flush_cnt", 96'(fc3), 96'd1);
        chk("flush d3 hold_cnt", 96'(hc3), 96'd3);

        // saturation of the 4-bit hold counter, then clear while holding
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0, 32'h0, 16'h0);
        @(negedge clk);
        chk("sat d1 hold_cnt", 96'(hc1), 96'd15);
        cyc(0, 1, 0, 0, 1, 0, 32'h0, 16'h0);
        @(negedge clk);
        chk("clr d1 hold_cnt", 96'(hc1), 96'd0);
        cyc(0, 1, 0, 0, 0, 0, 32'h0, 16'h0);
        @(negedge clk);
        chk("after clr d1 hold_cnt", 96'(hc1), 96'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(99) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                $urandom_range(11) == 0, $urandom_range(39) == 0, $urandom_range(3) != 0,
                $urandom, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (exp_q[d].size() != 0) begin
                bad++;
                $display("FAIL drain d%0d: pending=%0d required=0", d + 1, exp_q[d].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
